// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq -- multi-cycle shift/rotate sequencer
//
// Accepts an operand, a 3-bit shift opcode and a shift amount, then applies
// one single-bit step of the operation per clock until the amount is consumed.
// This lets the datapath perform multi-bit shifts without a barrel shifter.
// The opcode encoding matches the datapath's single-step shifter.
//
// Opcodes: 000 pass, 001 SHL (zero fill), 010 SHR (zero fill), 011 clear,
//          100 pass (or ASR, see below), 101 ROL, 110 ROR, 111 pass.
//
// Build option:
//   SHIFT_SEQ_ASR_EN  when defined, op 100 is an iterative arithmetic shift
//                     right (MSB replicated); when undefined it is a pass.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   op     in   3-bit opcode, sampled with start
//   amt    in   AW-bit shift amount, sampled with start
//   F      in   N-bit operand, sampled with start
//   S      out  result register; valid from done onwards, held until next start
//   busy   out  high while a request is in progress (RUN and DONE)
//   done   out  one-cycle pulse, S valid
// -----------------------------------------------------------------------------
module shift_seq #(
  parameter int N  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  F,
  output logic [N-1:0]  S,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [2:0]    r_op;
  logic [AW-1:0] r_cnt;
  logic [N-1:0]  r_s;
  logic          r_busy;
  logic          r_done;

  // Opcodes that take one clock per bit of shift amount.
  function automatic logic f_iterative(input logic [2:0] o);
    logic it;
    case (o)
      3'b001, 3'b010, 3'b101, 3'b110: it = 1'b1;
`ifdef SHIFT_SEQ_ASR_EN
      3'b100:                         it = 1'b1;
`endif
      default:                        it = 1'b0;
    endcase
    return it;
  endfunction

  // One single-bit step of the latched operation.
  function automatic logic [N-1:0] f_step(input logic [2:0] o, input logic [N-1:0] s);
    logic [N-1:0] nxt;
    case (o)
      3'b001:  nxt = {s[N-2:0], 1'b0};
      3'b010:  nxt = {1'b0, s[N-1:1]};
      3'b101:  nxt = {s[N-2:0], s[N-1]};
      3'b110:  nxt = {s[0], s[N-1:1]};
`ifdef SHIFT_SEQ_ASR_EN
      3'b100:  nxt = {s[N-1], s[N-1:1]};
`endif
      default: nxt = s;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= 3'b000;
      r_cnt   <= '0;
      r_s     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op   <= op;
            r_busy <= 1'b1;
            if (f_iterative(op) && (amt != '0)) begin
              r_s     <= F;
              r_cnt   <= amt;
              r_state <= ST_RUN;
            end else begin
              // Immediate result: clear for 011, operand for everything else
              // (including an iterative op with zero amount).
              r_s     <= (op == 3'b011) ? '0 : F;
              r_cnt   <= '0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_RUN: begin
          // Amounts >= N are not short-cut: each step is taken, so shifts
          // flush to zero and rotates wrap modulo N naturally.
          r_s   <= f_step(r_op, r_s);
          r_cnt <= r_cnt - AW'(1);
          if (r_cnt == AW'(1)) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // start is deliberately ignored here; first accept is next IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign S    = r_s;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;
  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op    = 3'b000;
  logic [AW-1:0] amt   = '0;
  logic [N-1:0]  F     = '0;
  logic [N-1:0]  S;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] q_s[$];
  int           q_lat[$];

  shift_seq #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amt(amt),
    .F(F), .S(S), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: closed-form result and done latency (edges after the accept).
  task automatic model(input logic [2:0] o, input logic [AW-1:0] a, input logic [N-1:0] f,
                       output logic [N-1:0] s, output int lat);
    bit it;
    int r;
    it = (o == 3'd1) || (o == 3'd2) || (o == 3'd5) || (o == 3'd6);
`ifdef SHIFT_SEQ_ASR_EN
    it = it || (o == 3'd4);
`endif
    lat = (it && a != 0) ? int'(a) : 0;
    r = int'(a) % N;
    case (o)
      3'd1: s = (a >= N) ? '0 : (f << a);
      3'd2: s = (a >= N) ? '0 : (f >> a);
      3'd3: s = '0;
      3'd5: s = (r == 0) ? f : ((f << r) | (f >> (N - r)));
      3'd6: s = (r == 0) ? f : ((f >> r) | (f << (N - r)));
`ifdef SHIFT_SEQ_ASR_EN
      3'd4: s = $signed(f) >>> a;
`endif
      default: s = f;
    endcase
  endtask

  // Drive one request; returns just after the accepting edge k.
  task automatic issue(input logic [2:0] o, input logic [AW-1:0] a, input logic [N-1:0] f);
    logic [N-1:0] es;
    int el;
    model(o, a, f, es, el);
    q_s.push_back(es);
    q_lat.push_back(el);
    @(negedge clk);
    op = o; amt = a; F = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done, compare against the scoreboard head.
  task automatic collect(input string tag, input int c0);
    logic [N-1:0] es;
    int el;
    int c;
    bit bz;
    es = q_s.pop_front();
    el = q_lat.pop_front();
    c  = c0;
    bz = 1'b1;
    while (done !== 1'b1 && c < 40) begin
      if (busy !== 1'b1) bz = 1'b0;
      @(posedge clk);
      #1 c++;
    end
    if (busy !== 1'b1) bz = 1'b0;
    check({tag, "_S"}, 32'(S), 32'(es));
    check({tag, "_lat"}, c, el);
    check({tag, "_busy"}, {31'b0, bz}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
    check({tag, "_S_hold"}, 32'(S), 32'(es));
  endtask

  initial begin
    logic [N-1:0] ds;
    int dl;
    bit seen;

    // Reset state
    #12;
    check("rst_S", 32'(S), 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // ROL 0x96 by 3 -> 0xB4, done after k+3, busy for 4 cycles
    issue(3'b101, 4'd3, 8'h96);
    collect("rol3", 0);

    // SHR 0xFF by 9 -> 0x00 after k+9
    issue(3'b010, 4'd9, 8'hFF);
    collect("shr9", 0);

    // ROR 0x96 by 8 -> 0x96 (full wrap)
    issue(3'b110, 4'd8, 8'h96);
    collect("ror8", 0);

    // SHL 0x81 by 15 -> 0, and ROL 0x81 by 9 -> 0x03
    issue(3'b001, 4'd15, 8'h81);
    collect("shl15", 0);
    issue(3'b101, 4'd9, 8'h81);
    collect("rol9", 0);

    // Clear: immediate, done right after k
    issue(3'b011, 4'd7, 8'hA5);
    collect("clr", 0);

    // SHL with amount 0: immediate pass
    issue(3'b001, 4'd0, 8'hA5);
    collect("shl0", 0);

    // Start raised during DONE cycle is ignored
    issue(3'b011, 4'd0, 8'hA5);
    ds = q_s.pop_front();
    dl = q_lat.pop_front();
    check("dstart_done", {31'b0, done}, 32'd1);
    check("dstart_S", 32'(S), 32'(ds));
    @(negedge clk);
    op = 3'b001; amt = 4'd0; F = 8'h11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("dstart_busy", {31'b0, busy}, 32'd0);
    check("dstart_S_hold", 32'(S), 32'h00);
    @(posedge clk);
    #1 check("dstart_no_done", {31'b0, done}, 32'd0);

    // Start with op 011 during a 5-step ROL is ignored
    issue(3'b101, 4'd5, 8'h96);
    @(negedge clk);
    op = 3'b011; amt = 4'd1; F = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    collect("busy_ign", 1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 if (done === 1'b1) seen = 1'b1;
    end
    check("busy_ign_no_extra", {31'b0, seen}, 32'd0);

    // Asynchronous reset during the second RUN cycle
    issue(3'b101, 4'd5, 8'h3C);
    ds = q_s.pop_front();
    dl = q_lat.pop_front();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_S", 32'(S), 32'h0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 if (done === 1'b1) seen = 1'b1;
    end
    check("arst_no_done", {31'b0, seen}, 32'd0);
    issue(3'b001, 4'd3, 8'h0F);
    collect("post_rst", 0);

    // Op 100: ASR when enabled, immediate pass otherwise
    issue(3'b100, 4'd2, 8'h96);
    collect("op100", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
